timer_apb_seq: RTL

TIMER_APB_SEQ -- requirements
Module: timer_apb_seq

---
 rtl/timer_apb_seq_if.sv | 52 +++++
 rtl/timer_apb_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_apb_seq_if.sv
// ---------------------------------------------------------------------------
// timer_apb_seq_if
// Bundles the requester handshakes, the completion report and the APB master
// bus of timer_apb_seq.
//   req0_*/req1_*       : two command requesters (valid/cmd/data in, ready out)
//   done/done_id/rdata/err : completion report, valid for one cycle
//   psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr : APB bus
// Modport master is the sequencer side; modport slave is the environment
// (requesters plus the APB slave).
// ---------------------------------------------------------------------------
interface timer_apb_seq_if;
    logic       req0_valid;
    logic [1:0] req0_cmd;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [1:0] req1_cmd;
    logic [7:0] req1_data;
    logic       req1_ready;

    logic       done;
    logic       done_id;
    logic [7:0] rdata;
    logic       err;

    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    modport master (
        input  req0_valid, req0_cmd, req0_data,
        input  req1_valid, req1_cmd, req1_data,
        output req0_ready, req1_ready,
        output done, done_id, rdata, err,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output req0_valid, req0_cmd, req0_data,
        output req1_valid, req1_cmd, req1_data,
        input  req0_ready, req1_ready,
        input  done, done_id, rdata, err,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/timer_apb_seq.sv
// ---------------------------------------------------------------------------
// timer_apb_seq
// Turns START/STOP/LOAD/READ commands from two round-robin arbitrated
// requesters into single APB transfers to a timer peripheral, and reports
// each completion with done/done_id/rdata/err.
// Ports:
//   pclk   : clock, all logic on the rising edge
//   preset : synchronous active-high reset
//   bus    : timer_apb_seq_if.master (requesters, completion report, APB)
// Parameters: ADDR_TDR, ADDR_TCR, ADDR_TCNT (register addresses), TIMEOUT
// (ACCESS cycles with pready low before a transfer is aborted).
// Optional feature: define TIMER_APB_SEQ_READBACK_EN to read back every
// successful write from the same address and flag a mismatch as an error.
// ---------------------------------------------------------------------------
module timer_apb_seq #(
    parameter logic [7:0] ADDR_TDR  = 8'h00,
    parameter logic [7:0] ADDR_TCR  = 8'h01,
    parameter logic [7:0] ADDR_TCNT = 8'h03,
    parameter int         TIMEOUT   = 16
) (
    input  logic            pclk,
    input  logic            preset,
    timer_apb_seq_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_LOAD  = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
`ifdef TIMER_APB_SEQ_READBACK_EN
        RB_SETUP,
        RB_ACCESS,
`endif
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            prio_q;
    logic            id_q;
    logic [TW-1:0]   tcnt_q;
    logic [7:0]      rdata_q;
    logic            err_q;
    logic [7:0]      paddr_q;
    logic [7:0]      pwdata_q;
    logic            pwrite_q;

    logic            any_req;
    logic            grant_id;
    logic [1:0]      sel_cmd;
    logic [7:0]      sel_data;
    logic            timeout_hit;

    // prio_q names the requester that wins when both are valid at once.
    assign any_req     = bus.req0_valid | bus.req1_valid;
    assign grant_id    = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
    assign sel_cmd     = grant_id ? bus.req1_cmd  : bus.req0_cmd;
    assign sel_data    = grant_id ? bus.req1_data : bus.req0_data;
    // Abort on the TIMEOUT-th consecutive low-pready cycle of an access.
    assign timeout_hit = (tcnt_q == TW'(TIMEOUT - 1));

    assign bus.paddr  = paddr_q;
    assign bus.pwdata = pwdata_q;
    assign bus.pwrite = pwrite_q;

    // Ready is only offered in IDLE and never while reset is held, so a
    // request raised during reset cannot appear accepted.
    assign bus.req0_ready = (state_q == IDLE) && !preset && any_req && !grant_id;
    assign bus.req1_ready = (state_q == IDLE) && !preset && any_req &&  grant_id;

    // Next-state and bus strobe decode; strobes follow the state directly so
    // a reset edge drops psel immediately.
    always_comb begin
        state_d     = state_q;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.done    = 1'b0;
        bus.done_id = 1'b0;
        bus.rdata   = 8'h00;
        bus.err     = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = SETUP;
            end
            SETUP: begin
                bus.psel = 1'b1;
                state_d  = ACCESS;
            end
            ACCESS: begin
                bus.psel    = 1'b1;
                bus.penable = 1'b1;
                if (bus.pready) begin
`ifdef TIMER_APB_SEQ_READBACK_EN
                    state_d = (pwrite_q && !bus.pslverr) ? RB_SETUP : DONE;
`else
                    state_d = DONE;
`endif
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
`ifdef TIMER_APB_SEQ_READBACK_EN
            RB_SETUP: begin
                bus.psel = 1'b1;
                state_d  = RB_ACCESS;
            end
            RB_ACCESS: begin
                bus.psel    = 1'b1;
                bus.penable = 1'b1;
                if (bus.pready || timeout_hit) state_d = DONE;
            end
`endif
            DONE: begin
                bus.done    = 1'b1;
                bus.done_id = id_q;
                bus.rdata   = rdata_q;
                bus.err     = err_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus the datapath: command decode at grant, timeout
    // counting and capture of the slave response.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            id_q     <= 1'b0;
            tcnt_q   <= '0;
            rdata_q  <= 8'h00;
            err_q    <= 1'b0;
            paddr_q  <= 8'h00;
            pwdata_q <= 8'h00;
            pwrite_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        id_q    <= grant_id;
                        prio_q  <= ~grant_id;
                        rdata_q <= 8'h00;
                        err_q   <= 1'b0;
                        case (sel_cmd)
                            CMD_START: begin
                                paddr_q  <= ADDR_TCR;
                                pwdata_q <= {3'b000, 1'b1, sel_data[3:0]};
                                pwrite_q <= 1'b1;
                            end
                            CMD_STOP: begin
                                paddr_q  <= ADDR_TCR;
                                pwdata_q <= 8'h00;
                                pwrite_q <= 1'b1;
                            end
                            CMD_LOAD: begin
                                paddr_q  <= ADDR_TDR;
                                pwdata_q <= sel_data;
                                pwrite_q <= 1'b1;
                            end
                            CMD_READ: begin
                                paddr_q  <= ADDR_TCNT;
                                pwrite_q <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                SETUP: tcnt_q <= '0;
                ACCESS: begin
                    if (bus.pready) begin
                        err_q <= bus.pslverr;
                        if (!pwrite_q) rdata_q <= bus.prdata;
`ifdef TIMER_APB_SEQ_READBACK_EN
                        // The readback reuses paddr/pwdata; only direction flips.
                        if (pwrite_q && !bus.pslverr) pwrite_q <= 1'b0;
`endif
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                        if (timeout_hit) err_q <= 1'b1;
                    end
                end
`ifdef TIMER_APB_SEQ_READBACK_EN
                RB_SETUP: tcnt_q <= '0;
                RB_ACCESS: begin
                    if (bus.pready) begin
                        rdata_q <= bus.prdata;
                        err_q   <= bus.pslverr | (bus.prdata != pwdata_q);
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                        if (timeout_hit) err_q <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
